// File: rtl/truth_table_capture_pkg.sv
// rtl/truth_table_capture_pkg.sv - shared types and constants for the truth-table sweep
// Purpose: FSM state encoding and vector geometry used by the capture block,
//          its interface and its settle timer.
package truth_table_capture_pkg;

    localparam int VEC_COUNT = 16;   // vectors in one sweep (2**N_INPUTS)
    localparam int N_INPUTS  = 4;    // stimulus pins driven to the circuit under test
    localparam int SETTLE_W  = 8;    // settle down-counter width

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_SAMPLE0 = 3'd2,
        ST_SAMPLE1 = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/truth_table_capture_if.sv
// rtl/truth_table_capture_if.sv - control, stimulus and result bundle of the capture block
// Purpose: groups every non-clock/reset signal of truth_table_capture.
// Ports (slave view):
//   start_i, abort_i   sweep request / terminate
//   expected_i         golden truth table, sampled on the accepted start
//   dut_out_i          output of the circuit under test
//   in1_o..in4_o       registered stimulus, in1_o is the MSB of the vector index
//   busy_o, done_o     sweep in progress / one-cycle completion pulse
//   table_o            captured truth table
//   mismatch_o         captured table differs from the latched golden table
//   unstable_o         some vector gave two different samples
interface truth_table_capture_if;
    import truth_table_capture_pkg::*;

    logic                 start_i;
    logic                 abort_i;
    logic [VEC_COUNT-1:0] expected_i;
    logic                 dut_out_i;
    logic                 in1_o;
    logic                 in2_o;
    logic                 in3_o;
    logic                 in4_o;
    logic                 busy_o;
    logic                 done_o;
    logic [VEC_COUNT-1:0] table_o;
    logic                 mismatch_o;
    logic                 unstable_o;

    modport master (
        output start_i, abort_i, expected_i, dut_out_i,
        input  in1_o, in2_o, in3_o, in4_o, busy_o, done_o, table_o, mismatch_o, unstable_o
    );

    modport slave (
        input  start_i, abort_i, expected_i, dut_out_i,
        output in1_o, in2_o, in3_o, in4_o, busy_o, done_o, table_o, mismatch_o, unstable_o
    );

endinterface

// File: rtl/truth_table_capture_settle_timer.sv
// rtl/truth_table_capture_settle_timer.sv - settle down-counter for the capture FSM
// Purpose: loaded on SETTLE entry, counts down each cycle; expired marks the
//          last settle cycle.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   load          load count_value this edge
//   count_value   number of settle cycles (1..255)
//   expired       high while the counter holds 1
module settle_timer
    import truth_table_capture_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [SETTLE_W-1:0] count_value,
    output logic                expired
);

    logic [SETTLE_W-1:0] count_q;
    logic [SETTLE_W-1:0] count_d;

    // Free-runs down to zero and parks there; only the value 1 matters.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = count_value;
        end else if (count_q != '0) begin
            count_d = count_q - SETTLE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == SETTLE_W'(1));

endmodule

// File: rtl/truth_table_capture.sv
// rtl/truth_table_capture.sv - sweeps 16 input vectors and captures a 4-input truth table
// Purpose: drives each vector, waits SETTLE_CYCLES, samples the circuit output
//          twice, and publishes table / mismatch / unstable on completion.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        truth_table_capture_if.slave (control, stimulus and results)
module truth_table_capture
    import truth_table_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
)
(
    input  logic                  clk,
    input  logic                  rst,
    truth_table_capture_if.slave  bus
);

    localparam logic [N_INPUTS-1:0] LAST_VEC = N_INPUTS'(VEC_COUNT - 1);

    state_t               state_q, state_d;
    logic [N_INPUTS-1:0]  vec_q, vec_d;          // index counter, also the stimulus
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [VEC_COUNT-1:0] table_q, table_d;
    logic                 mismatch_q, mismatch_d;
    logic                 unstable_q, unstable_d;
    logic [VEC_COUNT-1:0] exp_q, exp_d;
    logic [VEC_COUNT-1:0] work_q, work_d;        // table being built
    logic                 unst_work_q, unst_work_d;
    logic                 s0_q, s0_d;
    logic [N_INPUTS-1:0]  bit_pos;
    logic                 settle_load;
    logic                 settle_expired;

    // Index 0 lands in the MSB so the table reads left to right.
    assign bit_pos     = LAST_VEC - vec_q;
    assign settle_load = (state_d == ST_SETTLE) && (state_q != ST_SETTLE);

    settle_timer u_settle (
        .clk         (clk),
        .rst         (rst),
        .load        (settle_load),
        .count_value (SETTLE_W'(SETTLE_CYCLES)),
        .expired     (settle_expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (!bus.abort_i && bus.start_i) state_d = ST_SETTLE;
            ST_SETTLE:  if (bus.abort_i)                 state_d = ST_IDLE;
                        else if (settle_expired)         state_d = ST_SAMPLE0;
            ST_SAMPLE0: state_d = bus.abort_i ? ST_IDLE : ST_SAMPLE1;
            ST_SAMPLE1: if (bus.abort_i)                 state_d = ST_IDLE;
                        else if (vec_q == LAST_VEC)      state_d = ST_DONE;
                        else                             state_d = ST_SETTLE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Published results only change on completion, so an aborted sweep
    // leaves the previous table/mismatch/unstable visible.
    always_comb begin
        vec_d       = vec_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        table_d     = table_q;
        mismatch_d  = mismatch_q;
        unstable_d  = unstable_q;
        exp_d       = exp_q;
        work_d      = work_q;
        unst_work_d = unst_work_q;
        s0_d        = s0_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    exp_d       = bus.expected_i;
                    work_d      = '0;
                    unst_work_d = 1'b0;
                    vec_d       = '0;
                    busy_d      = 1'b1;
                end
            end
            ST_SETTLE, ST_SAMPLE0: begin
                if (bus.abort_i) begin
                    vec_d  = '0;
                    busy_d = 1'b0;
                end else if (state_q == ST_SAMPLE0) begin
                    s0_d = bus.dut_out_i;
                end
            end
            ST_SAMPLE1: begin
                if (bus.abort_i) begin
                    vec_d  = '0;
                    busy_d = 1'b0;
                end else begin
                    work_d[bit_pos] = bus.dut_out_i;
                    unst_work_d     = unst_work_q | (s0_q ^ bus.dut_out_i);
                    if (vec_q == LAST_VEC) begin
                        vec_d      = '0;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        table_d    = work_d;
                        mismatch_d = (work_d != exp_q);
                        unstable_d = unst_work_d;
                    end else begin
                        vec_d = vec_q + N_INPUTS'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            table_q     <= '0;
            mismatch_q  <= 1'b0;
            unstable_q  <= 1'b0;
            exp_q       <= '0;
            work_q      <= '0;
            unst_work_q <= 1'b0;
            s0_q        <= 1'b0;
        end else begin
            vec_q       <= vec_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            table_q     <= table_d;
            mismatch_q  <= mismatch_d;
            unstable_q  <= unstable_d;
            exp_q       <= exp_d;
            work_q      <= work_d;
            unst_work_q <= unst_work_d;
            s0_q        <= s0_d;
        end
    end

    assign {bus.in1_o, bus.in2_o, bus.in3_o, bus.in4_o} = vec_q;
    assign bus.busy_o     = busy_q;
    assign bus.done_o     = done_q;
    assign bus.table_o    = table_q;
    assign bus.mismatch_o = mismatch_q;
    assign bus.unstable_o = unstable_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// tb/tb_truth_table_capture.sv - self-checking bench for truth_table_capture
module tb_truth_table_capture;

    localparam int S       = 4;
    localparam int VEC_CYC = S + 2;
    localparam int SWEEP   = 16 * VEC_CYC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = 16'h0;
    int          mode = 0;
    bit          glitch_en = 1'b0;
    logic        glitch_r = 1'b0;
    logic [15:0] rnd_tbl = 16'h0;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model state
    bit          m_active = 1'b0;
    bit          m_done = 1'b0;
    int          m_k = 0;
    logic [15:0] m_table = 16'h0;
    logic [15:0] m_exp = 16'h0;
    logic [15:0] m_sweep_tbl = 16'h0;
    bit          m_mis = 1'b0;
    bit          m_unst = 1'b0;
    bit          m_sweep_unst = 1'b0;

    truth_table_capture_if tif ();

    truth_table_capture #(.SETTLE_CYCLES(S)) dut (
        .clk (clk),
        .rst (rst),
        .bus (tif)
    );

    always #5 clk = ~clk;

    function automatic logic f_eval(input int md, input logic [15:0] tbl, input logic [3:0] v);
        case (md)
            0:       return v[3];
            1:       return v[0];
            2:       return (v == 4'd0);
            3:       return 1'b1;
            default: return tbl[4'd15 - v];
        endcase
    endfunction

    assign tif.start_i    = start;
    assign tif.abort_i    = abort;
    assign tif.expected_i = expected;
    assign tif.dut_out_i  = f_eval(mode, rnd_tbl, {tif.in1_o, tif.in2_o, tif.in3_o, tif.in4_o}) ^ glitch_r;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle k after the accepted start drives vector k/(S+2); the sweep
    // publishes its table 16*(S+2) edges after the start edge.
    always @(posedge clk) begin : model
        bit was_done;
        was_done = m_done;
        m_done   = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_k      = 0;
            m_table  = 16'h0;
            m_mis    = 1'b0;
            m_unst   = 1'b0;
        end else if (m_active) begin
            if (abort) begin
                m_active = 1'b0;
            end else begin
                m_k++;
                if (m_k == SWEEP) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                    m_table  = m_sweep_tbl;
                    m_mis    = (m_sweep_tbl != m_exp);
                    m_unst   = m_sweep_unst;
                end
            end
        end else if (!was_done && start && !abort) begin
            m_active = 1'b1;
            m_k      = 0;
            m_exp    = expected;
            for (int i = 0; i < 16; i++)
                m_sweep_tbl[15-i] = f_eval(mode, rnd_tbl, 4'(i)) ^ (glitch_en && i == 5);
            m_sweep_unst = glitch_en;
        end
    end

    // Flip dut_out only during the second sample cycle of vector 5.
    always @(negedge clk) begin
        glitch_r = glitch_en && m_active && (m_k / VEC_CYC == 5) && (m_k % VEC_CYC == S + 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_vec", 16'({tif.in1_o, tif.in2_o, tif.in3_o, tif.in4_o}),
                m_active ? 16'(m_k / VEC_CYC) : 16'd0);
            chk("busy", 16'(tif.busy_o), 16'(m_active));
            chk("done", 16'(tif.done_o), 16'(m_done));
            chk("table", tif.table_o, m_table);
            chk("mismatch", 16'(tif.mismatch_o), 16'(m_mis));
            chk("unstable", 16'(tif.unstable_o), 16'(m_unst));
        end
    end

    task automatic run_sweep(output int lat);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!tif.done_o && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("sweep_done", 16'(tif.done_o), 16'd1);
        lat = n - 1;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin : stim
        int lat;
        int n;
        int cnt;
        bit do_ab;
        int ab_at;

        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_table_lit", tif.table_o, 16'h0000);
        chk("rst_busy_lit", 16'(tif.busy_o), 16'd0);
        chk("rst_in_lit", 16'({tif.in1_o, tif.in2_o, tif.in3_o, tif.in4_o}), 16'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Scenario 1: dut_out = in1
        mode = 0; expected = 16'h00FF;
        run_sweep(lat);
        chk("s1_latency", 16'(lat), 16'd96);
        chk("s1_table", tif.table_o, 16'h00FF);
        chk("s1_mismatch", 16'(tif.mismatch_o), 16'd0);
        chk("s1_unstable", 16'(tif.unstable_o), 16'd0);
        @(negedge clk);

        // Scenario 2: dut_out = in4
        mode = 1; expected = 16'h0000;
        run_sweep(lat);
        chk("s2_table", tif.table_o, 16'h5555);
        chk("s2_mismatch", 16'(tif.mismatch_o), 16'd1);
        @(negedge clk);

        // Scenario 3: NOR and constant 1
        mode = 2; expected = 16'h8000;
        run_sweep(lat);
        chk("s3_nor_table", tif.table_o, 16'h8000);
        chk("s3_nor_mismatch", 16'(tif.mismatch_o), 16'd0);
        @(negedge clk);
        mode = 3;
        run_sweep(lat);
        chk("s3_one_table", tif.table_o, 16'hFFFF);
        @(negedge clk);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_busy", 16'(tif.busy_o), 16'd0);
        @(negedge clk);

        // Scenario 4: toggle between samples of vector 5
        mode = 0; expected = 16'h00FF; glitch_en = 1'b1;
        run_sweep(lat);
        glitch_en = 1'b0;
        chk("s4_unstable", 16'(tif.unstable_o), 16'd1);
        chk("s4_bit10", 16'(tif.table_o[10]), 16'd1);
        chk("s4_table", tif.table_o, 16'h04FF);
        @(negedge clk);

        // Scenario 5: abort during vector 7
        mode = 1; expected = 16'h0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (m_k != 7 * VEC_CYC + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s5_reach", 16'(n < 200), 16'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("s5_in_zero", 16'({tif.in1_o, tif.in2_o, tif.in3_o, tif.in4_o}), 16'd0);
        chk("s5_busy", 16'(tif.busy_o), 16'd0);
        cnt = 0;
        repeat (110) begin
            @(negedge clk);
            if (tif.done_o) cnt++;
        end
        chk("s5_no_done", 16'(cnt), 16'd0);
        chk("s5_table_held", tif.table_o, 16'h04FF);
        chk("s5_unstable_held", 16'(tif.unstable_o), 16'd1);

        // Scenario 6: rst during vector 3 with start held
        mode = 0; expected = 16'h00FF;
        start = 1'b1;
        @(negedge clk);
        n = 0;
        while (m_k != 3 * VEC_CYC + 2 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("s6_reach", 16'(n < 200), 16'd1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("s6_rst_table", tif.table_o, 16'h0000);
        chk("s6_rst_busy", 16'(tif.busy_o), 16'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("s6_restart_busy", 16'(tif.busy_o), 16'd1);
        chk("s6_restart_vec", 16'({tif.in1_o, tif.in2_o, tif.in3_o, tif.in4_o}), 16'd0);
        n = 1;
        while (!tif.done_o && n < 300) begin
            start = (n < 10) || (n == 30) || (n == 60);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("s6_done", 16'(tif.done_o), 16'd1);
        chk("s6_latency", 16'(n - 1), 16'd96);
        chk("s6_table", tif.table_o, 16'h00FF);
        chk("s6_mismatch", 16'(tif.mismatch_o), 16'd0);
        @(negedge clk);

        // Randomized sweeps with stray starts and occasional aborts
        for (int r = 0; r < 20; r++) begin
            mode      = $urandom_range(0, 4);
            glitch_en = ($urandom_range(0, 3) == 0);
            rnd_tbl   = 16'($urandom);
            expected  = ($urandom_range(0, 1) == 1) ? rnd_tbl : 16'($urandom);
            do_ab     = ($urandom_range(0, 3) == 0);
            ab_at     = $urandom_range(0, SWEEP - 1);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            n = 0;
            while (m_active && n < 300) begin
                start = ($urandom_range(0, 7) == 0);
                abort = do_ab && (m_k == ab_at);
                @(negedge clk);
                n++;
            end
            start = 1'b0;
            abort = 1'b0;
            chk("rand_bound", 16'(n < 300), 16'd1);
            @(negedge clk);
        end
        glitch_en = 1'b0;

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/truth_table_capture.md
TRUTH_TABLE_CAPTURE -- requirements
Module: truth_table_capture

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, range 1..255: clock cycles the stimulus is held before sampling.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 start  input  1  one-cycle request to begin a 16-vector sweep; honoured only in IDLE.
REQ-005 abort  input  1  terminates a sweep in progress.
REQ-006 expected  input  16  golden truth table; sampled on the accepted start.
REQ-007 dut_out  input  1  output of the 4-input circuit under test.
REQ-008 in1, in2, in3, in4  output  1 each  registered stimulus to the circuit under test.
REQ-009 busy  output  1  high from the cycle after accepted start until DONE is entered.
REQ-010 done  output  1  one-cycle pulse when a sweep completes.
REQ-011 table  output  16  captured truth table; held stable outside a sweep.
REQ-012 mismatch  output  1  table differs from latched expected; valid with done.
REQ-013 unstable  output  1  at least one vector gave differing samples; valid with done.

Function
REQ-014 Vector index i (0..15) SHALL map as {in1,in2,in3,in4} = i, with in1 the MSB.
REQ-015 Captured value for index i SHALL be stored in table[15-i], so that index 0 is the leftmost hex digit's MSB.
REQ-016 FSM states SHALL be IDLE, SETTLE, SAMPLE0, SAMPLE1, DONE.
REQ-017 IDLE + start: latch expected, clear the working table, unstable and i, drive i=0 onto in1..in4, and enter SETTLE next cycle.
REQ-018 SETTLE SHALL last exactly SETTLE_CYCLES cycles with in1..in4 unchanged, then go to SAMPLE0.
REQ-019 SAMPLE0 SHALL capture dut_out to s0; SAMPLE1 SHALL capture dut_out to s1, write s1 into the table bit, and OR (s0 XOR s1) into unstable.
REQ-020 After SAMPLE1, if i<15, i increments, in1..in4 update to the new i in the same edge, and the FSM returns to SETTLE.
REQ-021 After SAMPLE1 with i=15, the FSM SHALL enter DONE.
REQ-022 DONE lasts one cycle and SHALL update the following: done=1, busy=0, table=working table, mismatch=(table != latched expected).
REQ-023 After DONE the FSM SHALL return to IDLE.
REQ-024 The sweep SHALL take 16*(SETTLE_CYCLES+2) cycles from the start edge to DONE entry.
REQ-025 start while not in IDLE SHALL be ignored; start and abort together in IDLE: abort wins and no sweep begins.
REQ-026 abort in SETTLE/SAMPLE0/SAMPLE1 SHALL return to IDLE next cycle with in1..in4=0 and busy=0, with no done pulse and with table, mismatch and unstable holding their pre-sweep values.
REQ-027 The index counter SHALL be 4 bits; it does not wrap because termination occurs at i=15.
REQ-028 The settle counter SHALL be 8 bits, loaded on SETTLE entry and counting down to 1.
REQ-029 In IDLE and DONE, in1..in4 SHALL be 0.

Reset
REQ-030 While rst=1: state=IDLE, in1..in4=0, busy=0, done=0, table=16'h0000, mismatch=0, unstable=0, and all counters=0.
REQ-031 rst mid-sweep SHALL discard the sweep without producing a done pulse; rst has priority over start and abort.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, VEC_COUNT=16 and N_INPUTS=4.
REQ-033 The settle down-counter SHALL be one sub-module, settle_timer, with inputs load and count_value and output expired.
REQ-034 All outputs SHALL be registered.

Verification
REQ-035 Scenario 1: dut_out modelled as in1 (combinational), SETTLE_CYCLES=4, expected=16'h00FF, start -> done after 96 cycles, table=16'h00FF, mismatch=0, unstable=0.
REQ-036 Scenario 2: dut_out modelled as in4, expected=16'h0000 -> table=16'h5555, mismatch=1.
REQ-037 Scenario 3: dut_out modelled as a 4-input NOR of in1..in4 -> table=16'h8000; with dut_out tied to 1 -> table=16'hFFFF.
REQ-038 Scenario 4: dut_out toggled between SAMPLE0 and SAMPLE1 of vector 5 only -> unstable=1, and table[10] equals the SAMPLE1 value.
REQ-039 Scenario 5: abort during vector 7 -> IDLE next cycle, in1..in4=0, no done pulse, and table unchanged from the previous sweep.
REQ-040 Scenario 6: rst during vector 3 with start held high -> after rst deasserts, a new sweep starts from i=0 and completes normally; start pulses during busy do not restart the sweep.
